lbist_seq_ctrl: RTL
===================

# lbist_seq_ctrl

LBIST sequencer that runs one complete self-test session around the pattern generator (LFSR), the scan chains and the output MISR. On `start` it initialises the LFSR and MISR and runs `num_patterns` shift/capture iterations. It then flushes the last captured response into the MISR, compares the signature with `golden`, and reports pass/fail. It sits in the LBIST top between the test-access/config registers and the TPG/scan/MISR datapath.

## Interface
Parameters:
- `N`, 24: MISR signature width.
- `SHIFT_LEN`, 16: scan-chain length in cycles; must be at least 1.
- `PAT_W`, 16: width of the pattern counter.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: single-cycle request to begin a session. It is sampled only in IDLE or DONE.
- `abort`, in, 1: synchronous abort. It returns the block to IDLE from any state.
- `num_patterns`, in, PAT_W: number of patterns. It is sampled on the cycle `start` is accepted.
- `golden`, in, N: expected signature. It must be stable from `start` until `done`.
- `misr_sig`, in, N: MISR `dout`.
- `tpg_init`, out, 1: one-cycle pulse that loads the LFSR seed.
- `misr_init`, out, 1: one-cycle pulse that reloads the MISR SEED. Integration ANDs the inverse of this pulse into the MISR `rst_n`.
- `tpg_en`, out, 1: advance the LFSR.
- `scan_en`, out, 1: 1 = shift, 0 = capture.
- `misr_en`, out, 1: MISR compaction enable.
- `busy`, out, 1: a session is in progress.
- `done`, out, 1: the session has completed. It is held until the next accepted `start`, `abort` or reset.
- `pass`, out, 1: result; valid while `done` = 1.

## Operation
All outputs are registered (Moore). Reset value of every output is 0.

State machine:
- **IDLE**: all outputs 0.
  - `start` → INIT.
- **INIT** (1 cycle): `tpg_init` = `misr_init` = `busy` = 1. The pattern counter is loaded with `num_patterns`.
  - If `num_patterns` = 0 → COMPARE. The signature compared is then the MISR SEED.
  - Otherwise → SHIFT.
- **SHIFT** (`SHIFT_LEN` cycles): `tpg_en` = `scan_en` = `misr_en` = `busy` = 1. The shift counter counts down from `SHIFT_LEN`-1 to 0.
  - At 0 → CAPTURE.
- **CAPTURE** (1 cycle): `busy` = 1; `tpg_en`, `scan_en` and `misr_en` are 0. The pattern counter decrements.
  - If the count was 1 → FLUSH.
  - Otherwise → SHIFT.
- **FLUSH** (`SHIFT_LEN` cycles): `scan_en` = `misr_en` = `busy` = 1; `tpg_en` = 0.
  - At 0 → COMPARE.
- **COMPARE** (1 cycle): `busy` = 1. The comparison `misr_sig == golden` is registered.
  - → DONE.
- **DONE**: `done` = 1; `pass` holds the registered compare result; `busy` = 0.
  - `start` → INIT. `done` and `pass` clear in that same cycle.

Boundary conditions:
- `abort` has priority over all transitions, including a simultaneous `start`. On the next edge the state is IDLE and all outputs are 0; there is no partial result.
- `start` while `busy` = 1 is ignored.
- Changes to `num_patterns` after `start` has been accepted have no effect on the running session.
- `num_patterns` = 2^PAT_W − 1 runs fully; there is no counter wrap.
- Reset mid-session: immediate IDLE, all outputs 0. The datapath is reinitialised by the next INIT.

## Timing
- `start` is accepted at edge T0. INIT is visible in cycle 1.
- For P ≥ 1 patterns and L = `SHIFT_LEN`:
  - `done` rises in cycle 1 + P·(L+1) + L + 1 + 1 after T0. That is 1 INIT cycle, P·(L+1) SHIFT/CAPTURE cycles, L FLUSH cycles, 1 COMPARE cycle, then DONE.
  - `misr_en` is high for exactly P·L + L cycles.
- For P = 0: `done` rises in cycle 3.
- `misr_sig` is sampled in the COMPARE cycle. This is one cycle after the last MISR update, so the MISR value is stable.
- `busy` is high from cycle 1 until the cycle before `done` rises.

## Structure
- Package `lbist_pkg`:
  - state enum `lbist_state_t` with values IDLE, INIT, SHIFT, CAPTURE, FLUSH, COMPARE, DONE;
  - `SHIFT_CNT_W = $clog2(SHIFT_LEN)` with a minimum of 1.
- Sub-module `lbist_dncnt`: loadable down-counter with a terminal-count flag. It is instantiated twice, once for shift cycles and once for patterns.
- The top-level block contains the FSM, the registered outputs and the compare register.

## Test plan
- Normal run with L=4, P=3 and `golden` equal to the MISR signature:
  - `done` rises in cycle 22;
  - `pass` = 1;
  - `misr_en` is high for 16 cycles;
  - `tpg_en` is high for 12 cycles.
- Same run with `golden` differing by bit 0: `pass` = 0, `done` = 1, and the timing is identical.
- `num_patterns` = 0: `done` rises in cycle 3, and `pass` = 1 when `golden` = SEED (100).
- `abort` in cycle 7 of the L=4, P=3 run: the next cycle is IDLE with all outputs 0. A new `start` then completes normally.
- `start` pulses in cycles 5 and 10 of a run are ignored: the same `done` cycle is reached. `start` in DONE clears `done`/`pass` and restarts with INIT pulses.
- `rst_n` asserted in SHIFT: all outputs are 0 asynchronously; after release the block stays in IDLE until `start`.

Source files
------------

// File: rtl/lbist_pkg.sv
// Shared definitions for the LBIST session sequencer.
//   lbist_state_t : sequencer FSM state encoding.
//   shift_cnt_w() : width of the shift-cycle counter for a given chain length
//                   ($clog2 of the length, never less than 1 bit).
package lbist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SHIFT,
    CAPTURE,
    FLUSH,
    COMPARE,
    DONE
  } lbist_state_t;

  // SHIFT_CNT_W = $clog2(SHIFT_LEN), minimum 1.
  function automatic int unsigned shift_cnt_w(input int unsigned len);
    int unsigned w;
    w = $clog2(len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lbist_dncnt.sv
// Loadable down-counter with terminal-count flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (highest priority)
//   load       : load load_val (beats dec)
//   load_val   : value to load
//   dec        : decrement; saturates at zero so it can never wrap
//   count      : current count
//   tc         : count == 0
module lbist_dncnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == '0);

endmodule

// File: rtl/lbist_seq_ctrl.sv
// LBIST session sequencer: INIT -> (SHIFT x SHIFT_LEN, CAPTURE) x num_patterns
// -> FLUSH x SHIFT_LEN -> COMPARE -> DONE, driving the TPG/scan/MISR datapath.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : session request, honoured only in IDLE or DONE
//   abort        : synchronous return to IDLE from any state (beats start)
//   num_patterns : pattern count, captured when start is accepted
//   golden       : expected signature, held stable for the whole session
//   misr_sig     : MISR signature, sampled in COMPARE
//   tpg_init     : LFSR seed-load pulse (INIT)
//   misr_init    : MISR seed-reload pulse (INIT)
//   tpg_en       : advance LFSR (SHIFT)
//   scan_en      : 1 = shift, 0 = capture (SHIFT, FLUSH)
//   misr_en      : MISR compaction enable (SHIFT, FLUSH)
//   busy         : session in progress (INIT..COMPARE)
//   done         : session complete, held in DONE
//   pass         : registered compare result, valid while done
// Every output is a flop whose next value is decoded from the next state, so
// outputs change on the same edge as the state.
module lbist_seq_ctrl
  import lbist_pkg::*;
#(
  parameter int unsigned N         = 24,
  parameter int unsigned SHIFT_LEN = 16,
  parameter int unsigned PAT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] num_patterns,
  input  logic [N-1:0]     golden,
  input  logic [N-1:0]     misr_sig,
  output logic             tpg_init,
  output logic             misr_init,
  output logic             tpg_en,
  output logic             scan_en,
  output logic             misr_en,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam int unsigned SHIFT_CNT_W = shift_cnt_w(SHIFT_LEN);
  localparam logic [SHIFT_CNT_W-1:0] SHIFT_LAST = SHIFT_CNT_W'(SHIFT_LEN - 1);

  lbist_state_t state_q, state_d;

  // Counter controls and status.
  logic                   shift_load, shift_dec, shift_tc;
  logic [SHIFT_CNT_W-1:0] shift_count;
  logic                   pat_load, pat_dec, pat_tc, pat_last;
  logic [PAT_W-1:0]       pat_count;
  logic [SHIFT_CNT_W-1:0] unused_shift_count;

  // Registered outputs.
  logic tpg_init_q, tpg_init_d;
  logic misr_init_q, misr_init_d;
  logic tpg_en_q, tpg_en_d;
  logic scan_en_q, scan_en_d;
  logic misr_en_q, misr_en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic pass_q, pass_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = INIT;
      INIT:    state_d = pat_tc ? COMPARE : SHIFT;
      SHIFT:   if (shift_tc) state_d = CAPTURE;
      // pat_count still holds the pre-decrement value here.
      CAPTURE: state_d = pat_last ? FLUSH : SHIFT;
      FLUSH:   if (shift_tc) state_d = COMPARE;
      COMPARE: state_d = DONE;
      DONE:    if (start) state_d = INIT;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  // Pattern count is captured on the accepting edge, so INIT can already branch
  // on it and later num_patterns changes are ignored.
  assign pat_load = (state_d == INIT);
  assign pat_dec  = (state_q == CAPTURE);
  assign pat_last = (pat_count == PAT_W'(1));

  // Shift counter is reloaded on every entry into a SHIFT or FLUSH burst and
  // runs SHIFT_LEN-1 .. 0.
  assign shift_load = ((state_d == SHIFT) && (state_q != SHIFT)) ||
                      ((state_d == FLUSH) && (state_q != FLUSH));
  assign shift_dec  = (state_q == SHIFT) || (state_q == FLUSH);

  lbist_dncnt #(
    .W (SHIFT_CNT_W)
  ) u_shift_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (abort),
    .load     (shift_load),
    .load_val (SHIFT_LAST),
    .dec      (shift_dec),
    .count    (shift_count),
    .tc       (shift_tc)
  );

  lbist_dncnt #(
    .W (PAT_W)
  ) u_pat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (abort),
    .load     (pat_load),
    .load_val (num_patterns),
    .dec      (pat_dec),
    .count    (pat_count),
    .tc       (pat_tc)
  );

  assign unused_shift_count = shift_count;

  // ---------------------------------------------------------------------------
  // Output decode from the next state
  // ---------------------------------------------------------------------------
  always_comb begin
    tpg_init_d  = 1'b0;
    misr_init_d = 1'b0;
    tpg_en_d    = 1'b0;
    scan_en_d   = 1'b0;
    misr_en_d   = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    pass_d      = 1'b0;
    unique case (state_d)
      INIT: begin
        tpg_init_d  = 1'b1;
        misr_init_d = 1'b1;
        busy_d      = 1'b1;
      end
      SHIFT: begin
        tpg_en_d  = 1'b1;
        scan_en_d = 1'b1;
        misr_en_d = 1'b1;
        busy_d    = 1'b1;
      end
      CAPTURE: busy_d = 1'b1;
      FLUSH: begin
        scan_en_d = 1'b1;
        misr_en_d = 1'b1;
        busy_d    = 1'b1;
      end
      COMPARE: busy_d = 1'b1;
      DONE: begin
        done_d = 1'b1;
        // misr_sig is stable in COMPARE: the last compaction was the edge before.
        pass_d = (state_q == COMPARE) ? (misr_sig == golden) : pass_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tpg_init_q  <= 1'b0;
      misr_init_q <= 1'b0;
      tpg_en_q    <= 1'b0;
      scan_en_q   <= 1'b0;
      misr_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      tpg_init_q  <= tpg_init_d;
      misr_init_q <= misr_init_d;
      tpg_en_q    <= tpg_en_d;
      scan_en_q   <= scan_en_d;
      misr_en_q   <= misr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign tpg_init  = tpg_init_q;
  assign misr_init = misr_init_q;
  assign tpg_en    = tpg_en_q;
  assign scan_en   = scan_en_q;
  assign misr_en   = misr_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule
